// File: rtl/memory_arbiter_4x36_pkg.sv
// Shared constants and state encoding for the four-port memory arbiter.
package memory_arbiter_4x36_pkg;

   localparam int unsigned NPORTS = 4;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

endpackage

// File: rtl/memory_arbiter_4x36_if.sv
// Avalon-style word-addressed memory port; master drives strobes, slave answers.
interface memory_arbiter_4x36_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 36
);
   logic [ADDR_W-1:0] address;
   logic              write;
   logic              read;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;

   modport master (
      output address, write, read, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, read, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/memory_arbiter_4x36_rr_pick4.sv
// Round-robin search over four requests, starting just after the last-served index.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       any,
   output logic [1:0] idx
);
   logic [1:0] cand;

   // Walk from farthest to nearest so the nearest hit after last is what remains.
   always_comb begin
      any  = |req;
      idx  = last;
      cand = last;
      for (int k = 4; k >= 1; k--) begin
         cand = last + 2'(k);
         if (req[cand]) idx = cand;
      end
   end
endmodule

// File: rtl/memory_arbiter_4x36.sv
// Four requesters share one memory port; round-robin grant held until the transfer completes.
module memory_arbiter_4x36
   import memory_arbiter_4x36_pkg::*;
#(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 36
) (
   input  logic                   clk,
   input  logic                   reset,
   memory_arbiter_4x36_if.slave   p0,
   memory_arbiter_4x36_if.slave   p1,
   memory_arbiter_4x36_if.slave   p2,
   memory_arbiter_4x36_if.slave   p3,
   memory_arbiter_4x36_if.master  m
);
   logic [NPORTS-1:0] rd;
   logic [NPORTS-1:0] wr;
   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] wt;
   logic [ADDR_W-1:0] addr  [NPORTS];
   logic [DATA_W-1:0] wdata [NPORTS];

   state_t     state_q, state_d;
   logic [1:0] g_q, g_d;
   logic [1:0] last_q, last_d;
   logic       any;
   logic [1:0] pick;
   logic       granted;

   assign rd  = {p3.read, p2.read, p1.read, p0.read};
   assign wr  = {p3.write, p2.write, p1.write, p0.write};
   assign req = rd | wr;

   assign addr[0]  = p0.address;
   assign addr[1]  = p1.address;
   assign addr[2]  = p2.address;
   assign addr[3]  = p3.address;
   assign wdata[0] = p0.writedata;
   assign wdata[1] = p1.writedata;
   assign wdata[2] = p2.writedata;
   assign wdata[3] = p3.writedata;

   rr_pick4 u_pick (
      .req  (req),
      .last (last_q),
      .any  (any),
      .idx  (pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         g_q     <= 2'd0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         last_q  <= last_d;
      end
   end

   // A withdrawn request releases the grant exactly like a completed one.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               state_d = ST_GRANT;
               g_d     = pick;
            end
         end
         ST_GRANT: begin
            if (!req[g_q] || !m.waitrequest) begin
               state_d = ST_IDLE;
               last_d  = g_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign granted     = (state_q == ST_GRANT);
   assign m.address   = addr[g_q];
   assign m.writedata = wdata[g_q];
   assign m.write     = granted & wr[g_q];
   assign m.read      = granted & rd[g_q] & ~wr[g_q];

   always_comb begin
      wt = '1;
      for (int n = 0; n < NPORTS; n++) begin
         if (granted && (g_q == 2'(n))) wt[n] = m.waitrequest;
      end
   end

   assign p0.waitrequest = wt[0];
   assign p1.waitrequest = wt[1];
   assign p2.waitrequest = wt[2];
   assign p3.waitrequest = wt[3];
   assign p0.readdata    = m.readdata;
   assign p1.readdata    = m.readdata;
   assign p2.readdata    = m.readdata;
   assign p3.readdata    = m.readdata;
endmodule

// File: doc/memory_arbiter_4x36.md
Name: memory_arbiter_4x36

Overview:
- Shares one 36-bit word-addressed memory slave port (the 18-bit-address, 36-bit-data Avalon-style port of the 256K DRAM bridge) among four 36-bit requesters.
- Requesters are, e.g., the CPU, the data channel and the console/front-panel.
- Round-robin arbitration with grant held until the granted transfer completes.
- Sits between the requesters and the memory bridge.

Parameters:
ADDR_W, 18, word address width of requester and memory ports
DATA_W, 36, data width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pN_address  input  ADDR_W  requester N word address (N = 0..3, four identical port groups)
pN_write  input  1  requester N write request
pN_read  input  1  requester N read request
pN_writedata  input  DATA_W  requester N write data
pN_readdata  output  DATA_W  requester N read data
pN_waitrequest  output  1  requester N stall
m_address  output  ADDR_W  to memory slave
m_write  output  1  to memory slave
m_read  output  1  to memory slave
m_writedata  output  DATA_W  to memory slave
m_readdata  input  DATA_W  from memory slave
m_waitrequest  input  1  from memory slave

Behaviour:
- Clock and reset: clk rising edge; reset asynchronous, active-high.
- Request definition: reqN = pN_read | pN_write. Requesters hold address, data and strobes stable while waitrequest is high (Avalon rule).
- State register: state in {IDLE, GRANT}, grant index g[1:0], last-served index last[1:0].
- Reset values: state=IDLE, g=0, last=3, so port 0 has first priority.
- IDLE:
  - All pN_waitrequest=1; m_read=m_write=0.
  - If any reqN: pick the first requester searching last+1, last+2, ... mod 4; load g; go to GRANT.
  - Arbitration costs exactly 1 cycle.
- GRANT:
  - m_address, m_writedata, m_read and m_write are driven combinationally from port g.
  - pg_waitrequest = m_waitrequest; all other ports' waitrequest = 1.
- Completion: in GRANT, a cycle with reqg=1 and m_waitrequest=0 completes the transfer.
  - Next state is IDLE, last<=g.
  - Back-to-back accesses from one port therefore take at least 2 cycles each.
- Abandon: in GRANT, if reqg=0 (requester withdrew, protocol violation), go to IDLE with last<=g; no memory strobe is issued that cycle.
- Read data: pN_readdata = m_readdata for all N, combinationally. Valid only for port g in its completion cycle of a read.
- Simultaneous read and write on one port is illegal. Arbiter resolves it by write-wins: m_read = pg_read & ~pg_write.
- Requests from non-granted ports are never lost; they stay pending under waitrequest=1 until served.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,...; no port waits more than 3 other transfers.
- Reset asserted mid-transfer: outputs go immediately to reset values (strobes 0, all waitrequest 1); any in-flight memory access is abandoned.
- Output registers: none beyond state, g and last. All m_* and pN_* outputs are combinational from state, g and the inputs.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_GRANT) and the port count constant NPORTS=4.
- Sub-module: rr_pick4, purely combinational. Inputs are the req[3:0] vector and last[1:0]; outputs are any and the next index. Keeps the round-robin search separately testable.

Test Plan:
- Single request: after reset, p2_read with address 18'o1234, m_waitrequest=0.
  - Cycle 1: IDLE with p2_waitrequest=1.
  - Cycle 2: m_read=1, m_address=18'o1234, p2_waitrequest=0, p2_readdata=m_readdata.
  - Cycle 3: IDLE.
- Contention: p0, p1 and p3 write simultaneously with m_waitrequest=0.
  - Grants occur in order 0, 1, 3, each on alternate cycles.
  - m_writedata matches each port's data; losers keep waitrequest=1 until served.
- Memory stall: grant p1 write, hold m_waitrequest=1 for 5 cycles.
  - p1_waitrequest=1 and m_write=1 throughout.
  - Completion on the 6th cycle; last=1.
- Round-robin wrap: last=3, then all four request continuously for 8 transfers.
  - Grant sequence is 0,1,2,3,0,1,2,3.
- Abandon and illegal strobe:
  - Grant p0, then deassert p0_read before completion → IDLE next cycle with no strobe.
  - p2_read=p2_write=1 → m_write=1, m_read=0.
- Async reset mid-transfer: assert reset between clock edges while in GRANT with m_waitrequest=1.
  - m_read and m_write drop to 0 and all waitrequest go to 1 without a clock edge.
  - After release, port 0 wins first.
